// File: rtl/egg_timer_pkg.sv
// Shared types, constants and the saturating add used by the egg timer controller.
package egg_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_e;

    localparam int SEC_PER_MIN = 60;
    localparam int COUNT_W     = 12;

    // One extra bit of headroom so the sum can never wrap before the limit compare.
    function automatic logic [COUNT_W-1:0] sat_add(
        input logic [COUNT_W-1:0] a,
        input logic [COUNT_W-1:0] inc,
        input logic [COUNT_W-1:0] lim
    );
        logic [COUNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        return (sum > {1'b0, lim}) ? lim : sum[COUNT_W-1:0];
    endfunction

endpackage

// File: rtl/egg_timer_ctrl_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled, strobes tick on the wrap cycle.
module tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

    logic [W-1:0] cnt_q;

    // Combinational so the controller acts on the very edge where the prescaler wraps.
    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || !en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer sequencer: set buttons, start/pause/resume, 1 s countdown and timed alarm.
//  state | meaning
//  IDLE  | count settable, waiting for start
//  RUN   | counting down once per tick
//  PAUSE | count held, settable, start resumes
//  ALARM | count reached zero, alarm held for ALARM_SECS ticks
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int MAX_COUNT  = 3599,
    parameter int ALARM_SECS = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_min,
    input  logic               btn_sec,
    input  logic               btn_start_stop,
    input  logic               btn_clear,
    output logic [COUNT_W-1:0] count,
    output logic               running,
    output logic               alarm,
    output logic               tick
);

    localparam int ACW = $clog2(ALARM_SECS + 1);
    localparam logic [COUNT_W-1:0] MAX_C      = COUNT_W'(MAX_COUNT);
    localparam logic [COUNT_W-1:0] MIN_INC    = COUNT_W'(SEC_PER_MIN);
    localparam logic [COUNT_W-1:0] ONE        = COUNT_W'(1);
    localparam logic [ACW-1:0]     ALARM_LAST = ACW'(ALARM_SECS - 1);

    state_e             state_q;
    logic [COUNT_W-1:0] count_q;
    logic [ACW-1:0]     alarm_cnt_q;
    logic               running_q;
    logic               alarm_q;
    logic               tick_q;
    logic               wrap;
    logic               pre_en;
    logic               pre_clr;

    // Entry into ALARM only happens on a wrap, where the prescaler returns to 0 anyway.
    always_comb begin
        pre_en  = (state_q == RUN) || (state_q == ALARM);
        pre_clr = btn_clear
               || (btn_start_stop && (((state_q == IDLE) && (count_q != '0))
                                      || (state_q == PAUSE)));
    end

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            alarm_cnt_q <= '0;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            tick_q <= wrap && !btn_clear;
            if (btn_clear) begin
                state_q     <= IDLE;
                count_q     <= '0;
                alarm_cnt_q <= '0;
                running_q   <= 1'b0;
                alarm_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, PAUSE: begin
                        if (btn_start_stop) begin
                            if ((state_q == PAUSE) || (count_q != '0)) begin
                                state_q   <= RUN;
                                running_q <= 1'b1;
                            end
                        end else if (btn_min) begin
                            count_q <= sat_add(count_q, MIN_INC, MAX_C);
                        end else if (btn_sec) begin
                            count_q <= sat_add(count_q, ONE, MAX_C);
                        end
                    end
                    RUN: begin
                        if (wrap && (count_q == ONE)) begin
                            count_q     <= '0;
                            state_q     <= ALARM;
                            running_q   <= 1'b0;
                            alarm_q     <= 1'b1;
                            alarm_cnt_q <= '0;
                        end else begin
                            if (wrap && (count_q != '0)) begin
                                count_q <= count_q - 1'b1;
                            end
                            if (btn_start_stop) begin
                                state_q   <= PAUSE;
                                running_q <= 1'b0;
                            end
                        end
                    end
                    ALARM: begin
                        if (btn_start_stop || (wrap && (alarm_cnt_q == ALARM_LAST))) begin
                            state_q     <= IDLE;
                            alarm_q     <= 1'b0;
                            alarm_cnt_q <= '0;
                        end else if (wrap) begin
                            alarm_cnt_q <= alarm_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                        alarm_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign alarm   = alarm_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed bench for egg_timer_ctrl with a 10-cycle second and a 3-tick alarm.
module tb_egg_timer_ctrl;

    localparam int CLK_HZ     = 10;
    localparam int MAX_COUNT  = 3599;
    localparam int ALARM_SECS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_min = 1'b0;
    logic        btn_sec = 1'b0;
    logic        btn_start_stop = 1'b0;
    logic        btn_clear = 1'b0;
    logic [11:0] count;
    logic        running;
    logic        alarm;
    logic        tick;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    egg_timer_ctrl #(
        .CLK_HZ     (CLK_HZ),
        .MAX_COUNT  (MAX_COUNT),
        .ALARM_SECS (ALARM_SECS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_min        (btn_min),
        .btn_sec        (btn_sec),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .count          (count),
        .running        (running),
        .alarm          (alarm),
        .tick           (tick)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input logic m, input logic s, input logic st, input logic c);
        btn_min = m;
        btn_sec = s;
        btn_start_stop = st;
        btn_clear = c;
        cyc();
        btn_min = 1'b0;
        btn_sec = 1'b0;
        btn_start_stop = 1'b0;
        btn_clear = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({count, running, alarm, tick} !== {12'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in count=%0d run=%b alarm=%b tick=%b expected 0 0 0 0", count, running, alarm, tick);
        end
        rst_n = 1'b1;
        cyc();
        checks++;
        if ({count, running, alarm, tick} !== {12'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_out count=%0d run=%b alarm=%b tick=%b expected 0 0 0 0", count, running, alarm, tick);
        end
    endtask

    task automatic test_countdown();
        repeat (3) press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({count, running} !== {12'd3, 1'b1}) begin
            errors++;
            $display("FAIL cd_start count=%0d run=%b expected 3 1", count, running);
        end
        repeat (9) cyc();
        checks++;
        if ({count, tick} !== {12'd3, 1'b0}) begin
            errors++;
            $display("FAIL cd_e9 count=%0d tick=%b expected 3 0", count, tick);
        end
        cyc();
        checks++;
        if ({count, tick} !== {12'd2, 1'b1}) begin
            errors++;
            $display("FAIL cd_e10 count=%0d tick=%b expected 2 1", count, tick);
        end
        cyc();
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL cd_tick_width tick=%b expected 0", tick);
        end
        repeat (9) cyc();
        checks++;
        if (count !== 12'd1) begin
            errors++;
            $display("FAIL cd_e20 count=%0d expected 1", count);
        end
        repeat (9) cyc();
        checks++;
        if ({count, alarm} !== {12'd1, 1'b0}) begin
            errors++;
            $display("FAIL cd_e29 count=%0d alarm=%b expected 1 0", count, alarm);
        end
        cyc();
        checks++;
        if ({count, running, alarm} !== {12'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL cd_e30 count=%0d run=%b alarm=%b expected 0 0 1", count, running, alarm);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({count, running, alarm} !== {12'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL cd_clear count=%0d run=%b alarm=%b expected 0 0 0", count, running, alarm);
        end
    endtask

    task automatic test_alarm();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) cyc();
        checks++;
        if ({count, alarm} !== {12'd0, 1'b1}) begin
            errors++;
            $display("FAIL al_enter count=%0d alarm=%b expected 0 1", count, alarm);
        end
        repeat (29) cyc();
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL al_hold29 alarm=%b expected 1", alarm);
        end
        cyc();
        checks++;
        if ({count, running, alarm} !== {12'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL al_expire count=%0d run=%b alarm=%b expected 0 0 0", count, running, alarm);
        end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) cyc();
        repeat (4) cyc();
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL al_before_ack alarm=%b expected 1", alarm);
        end
        press(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({alarm, running, count} !== {1'b0, 1'b0, 12'd0}) begin
            errors++;
            $display("FAIL al_ack alarm=%b run=%b count=%0d expected 0 0 0", alarm, running, count);
        end
        repeat (20) cyc();
        checks++;
        if ({alarm, running, count} !== {1'b0, 1'b0, 12'd0}) begin
            errors++;
            $display("FAIL al_ack_stays alarm=%b run=%b count=%0d expected 0 0 0", alarm, running, count);
        end
    endtask

    task automatic test_saturate();
        repeat (59) press(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 12'd3540) begin
            errors++;
            $display("FAIL sat_59min count=%0d expected 3540", count);
        end
        press(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 12'd3599) begin
            errors++;
            $display("FAIL sat_60min count=%0d expected 3599", count);
        end
        repeat (5) press(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (count !== 12'd3599) begin
            errors++;
            $display("FAIL sat_sec count=%0d expected 3599", count);
        end
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({running, count} !== {1'b1, 12'd3599}) begin
            errors++;
            $display("FAIL sat_run_ignore run=%b count=%0d expected 1 3599", running, count);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_pause();
        logic saw_tick;
        repeat (5) press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (14) cyc();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({running, count} !== {1'b0, 12'd4}) begin
            errors++;
            $display("FAIL pause_enter run=%b count=%0d expected 0 4", running, count);
        end
        saw_tick = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (tick) saw_tick = 1'b1;
        end
        checks++;
        if ({saw_tick, count} !== {1'b0, 12'd4}) begin
            errors++;
            $display("FAIL pause_hold tick_seen=%b count=%0d expected 0 4", saw_tick, count);
        end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (count !== 12'd5) begin
            errors++;
            $display("FAIL pause_set count=%0d expected 5", count);
        end
        press(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (9) cyc();
        checks++;
        if ({running, count} !== {1'b1, 12'd5}) begin
            errors++;
            $display("FAIL resume_e9 run=%b count=%0d expected 1 5", running, count);
        end
        cyc();
        checks++;
        if (count !== 12'd4) begin
            errors++;
            $display("FAIL resume_e10 count=%0d expected 4", count);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_start_zero_priority();
        logic saw_tick;
        press(1'b0, 1'b0, 1'b1, 1'b0);
        saw_tick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (tick || running) saw_tick = 1'b1;
        end
        checks++;
        if ({saw_tick, running, count} !== {1'b0, 1'b0, 12'd0}) begin
            errors++;
            $display("FAIL start_zero activity=%b run=%b count=%0d expected 0 0 0", saw_tick, running, count);
        end
        press(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (count !== 12'd60) begin
            errors++;
            $display("FAIL prio_min_sec count=%0d expected 60", count);
        end
        press(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (count !== 12'd0) begin
            errors++;
            $display("FAIL prio_clear_min count=%0d expected 0", count);
        end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({running, count} !== {1'b1, 12'd1}) begin
            errors++;
            $display("FAIL prio_start_min run=%b count=%0d expected 1 1", running, count);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        repeat (3) press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (9) cyc();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({running, alarm, count} !== {1'b0, 1'b0, 12'd2}) begin
            errors++;
            $display("FAIL tick_and_pause run=%b alarm=%b count=%0d expected 0 0 2", running, alarm, count);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (9) cyc();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({running, alarm, count} !== {1'b0, 1'b1, 12'd0}) begin
            errors++;
            $display("FAIL expiry_wins run=%b alarm=%b count=%0d expected 0 1 0", running, alarm, count);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        repeat (42) press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc();
        checks++;
        if ({running, count} !== {1'b1, 12'd42}) begin
            errors++;
            $display("FAIL ar_pre run=%b count=%0d expected 1 42", running, count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({count, running, alarm, tick} !== {12'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ar_async count=%0d run=%b alarm=%b tick=%b expected 0 0 0 0", count, running, alarm, tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) cyc();
        checks++;
        if ({count, running, alarm} !== {12'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ar_after count=%0d run=%b alarm=%b expected 0 0 0", count, running, alarm);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_countdown();
        test_alarm();
        test_saturate();
        test_pause();
        test_start_zero_priority();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
